dma_write_controller: RTL and testbench

- Device-to-host DMA engine; the counterpart of the host-to-device read path.
- Reads device memory through an AXI4 read master (AR/R channels) and buffers each chunk in an internal FIFO.
- Issues PCIe memory-write requests to the TLP engine, which pulls the payload from this block.
- Splits transfers so that no chunk exceeds max payload size and no chunk crosses a host 4 KB boundary.

---
 rtl/dma_write_controller.sv | 205 ++++++++++++++++++++
 tb/tb_dma_write_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_write_controller.sv
// Device-to-host DMA write engine: AXI4 read of device memory, buffered
// in a FWFT FIFO, then handed to the PCIe TLP engine in MPS/4KB chunks.
module dma_write_controller #(
  parameter int P_FIFO_DEPTH_BITS = 6,
  parameter int P_MPS_CAP         = 512
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [15:0]  pcie_dcommand,
  input  logic [31:0]  dma_write_host_address,
  input  logic [31:0]  dma_write_device_address,
  input  logic [31:0]  dma_write_length,
  input  logic         dma_write_start,
  output logic         dma_write_busy,
  output logic         dma_write_complete,
  output logic         dma_write_error,
  output logic [31:0]  dma_write_addr,
  output logic [9:0]   dma_write_len,
  output logic         dma_write_valid,
  input  logic         dma_write_done,
  output logic [127:0] dma_write_data,
  output logic         dma_write_data_empty,
  input  logic         dma_write_data_rd,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [3:0]   arcache,
  output logic [2:0]   arproto,
  output logic         arvalid,
  input  logic         arready,
  input  logic [127:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  localparam int PB = P_FIFO_DEPTH_BITS;
  localparam int DEPTH = 1 << PB;
  localparam logic [12:0] CAP = 13'(P_MPS_CAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_AR,
    S_FILL,
    S_REQ
  } state_t;

  state_t state, state_nx;

  logic [31:0] host_q, dev_q, rem_q, rem_nx;
  logic [12:0] chunk_q, chunk, mps, mps_raw, bound;
  logic [7:0]  beats;
  logic        last_beat, push, pop, full;
  logic [PB:0] wptr, rptr;
  logic [127:0] mem [DEPTH];
  logic        unused;

  assign unused = ^{pcie_dcommand[15:8], pcie_dcommand[4:0]};

  assign arsize  = 3'b100;
  assign arburst = 2'b01;
  assign arcache = 4'b0011;
  assign arproto = 3'b000;

  always_comb begin
    unique case (pcie_dcommand[7:5])
      3'd0:    mps_raw = 13'd128;
      3'd1:    mps_raw = 13'd256;
      3'd2:    mps_raw = 13'd512;
      default: mps_raw = CAP;
    endcase
    mps = (mps_raw > CAP) ? CAP : mps_raw;
  end

  assign bound = 13'd4096 - {1'b0, host_q[11:0]};

  always_comb begin
    chunk = mps;
    if (bound < chunk) chunk = bound;
    if (rem_q < {19'd0, chunk}) chunk = rem_q[12:0];
  end

  assign rem_nx    = rem_q - {19'd0, chunk_q};
  assign last_beat = rlast || (beats == arlen);
  assign push      = (state == S_FILL) && rvalid && !full;
  assign pop       = dma_write_data_rd && !dma_write_data_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    arvalid         = 1'b0;
    rready          = 1'b0;
    dma_write_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (dma_write_start && !dma_write_busy &&
            dma_write_length != 32'd0)
          state_nx = S_CALC;
      end
      S_CALC: state_nx = S_AR;
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_nx = S_FILL;
      end
      S_FILL: begin
        rready = 1'b1;
        if (rvalid && last_beat) state_nx = S_REQ;
      end
      S_REQ: begin
        dma_write_valid = 1'b1;
        if (dma_write_done)
          state_nx = (rem_nx == 32'd0) ? S_IDLE : S_CALC;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      host_q             <= '0;
      dev_q              <= '0;
      rem_q              <= '0;
      chunk_q            <= '0;
      beats              <= '0;
      araddr             <= '0;
      arlen              <= '0;
      dma_write_addr     <= '0;
      dma_write_len      <= '0;
      dma_write_busy     <= 1'b0;
      dma_write_complete <= 1'b0;
      dma_write_error    <= 1'b0;
    end else begin
      dma_write_complete <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // busy lingers one cycle after a zero-length start
          if (dma_write_busy) begin
            dma_write_busy <= 1'b0;
          end else if (dma_write_start) begin
            host_q          <= dma_write_host_address;
            dev_q           <= dma_write_device_address;
            rem_q           <= dma_write_length;
            dma_write_error <= 1'b0;
            dma_write_busy  <= 1'b1;
            if (dma_write_length == 32'd0)
              dma_write_complete <= 1'b1;
          end
        end
        S_CALC: begin
          chunk_q        <= chunk;
          araddr         <= dev_q;
          arlen          <= chunk[11:4] - 8'd1;
          dma_write_addr <= host_q;
          dma_write_len  <= chunk[11:2];
          beats          <= '0;
        end
        S_FILL: begin
          if (rvalid) begin
            beats <= beats + 8'd1;
            if (rresp != 2'b00) dma_write_error <= 1'b1;
          end
        end
        S_REQ: begin
          if (dma_write_done) begin
            host_q <= host_q + {19'd0, chunk_q};
            dev_q  <= dev_q + {19'd0, chunk_q};
            rem_q  <= rem_nx;
            if (rem_nx == 32'd0) begin
              dma_write_complete <= 1'b1;
              dma_write_busy     <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr[PB-1:0]] <= rdata;
  end

  assign full = (wptr[PB] != rptr[PB]) &&
                (wptr[PB-1:0] == rptr[PB-1:0]);
  assign dma_write_data_empty = (wptr == rptr);
  assign dma_write_data = mem[rptr[PB-1:0]];

endmodule

// File: tb/tb_dma_write_controller.sv
// Directed self-checking bench for dma_write_controller.
// Acts as AXI read slave and TLP engine with hand-computed expectations.
module tb_dma_write_controller;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  dcmd = '0;
  logic [31:0]  h_addr = '0, d_addr = '0, x_len = '0;
  logic         start = 1'b0;
  logic         busy, complete, error;
  logic [31:0]  w_addr;
  logic [9:0]   w_len;
  logic         w_valid;
  logic         done = 1'b0;
  logic [127:0] w_data;
  logic         w_empty;
  logic         w_rd = 1'b0;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arcache;
  logic [2:0]   arproto;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [127:0] rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;

  int compared = 0;
  int mism = 0;
  int seed = 0;
  logic [127:0] exp_beats [32];

  dma_write_controller dut (
    .i_clk(clk),
    .i_rst(rst),
    .pcie_dcommand(dcmd),
    .dma_write_host_address(h_addr),
    .dma_write_device_address(d_addr),
    .dma_write_length(x_len),
    .dma_write_start(start),
    .dma_write_busy(busy),
    .dma_write_complete(complete),
    .dma_write_error(error),
    .dma_write_addr(w_addr),
    .dma_write_len(w_len),
    .dma_write_valid(w_valid),
    .dma_write_done(done),
    .dma_write_data(w_data),
    .dma_write_data_empty(w_empty),
    .dma_write_data_rd(w_rd),
    .araddr(araddr),
    .arlen(arlen),
    .arsize(arsize),
    .arburst(arburst),
    .arcache(arcache),
    .arproto(arproto),
    .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata),
    .rresp(rresp),
    .rlast(rlast),
    .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 1'b0);
    chk("rst_complete", complete, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_valid", w_valid, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_addr", w_addr, 32'd0);
    chk("rst_len", w_len, 10'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_empty", w_empty, 1'b1);
  endtask

  task automatic start_xfer(input logic [31:0] h,
                            input logic [31:0] d,
                            input logic [31:0] l,
                            input logic [2:0]  code);
    dcmd   = {8'h00, code, 5'h00};
    h_addr = h;
    d_addr = d;
    x_len  = l;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_err_clr", error, 1'b0);
    chk("calc_no_ar", arvalid, 1'b0);
    if (l != 32'd0) begin
      tick();
      chk("ar_latency", arvalid, 1'b1);
    end
  endtask

  task automatic do_chunk(input logic [31:0] e_araddr,
                          input logic [7:0]  e_arlen,
                          input logic [31:0] e_addr,
                          input logic [9:0]  e_len,
                          input int          err_beat,
                          input bit          last);
    int n;
    n = int'(e_arlen) + 1;
    for (int i = 0; i < 40 && !arvalid; i++) tick();
    chk("arvalid", arvalid, 1'b1);
    chk("araddr", araddr, e_araddr);
    chk("arlen", arlen, e_arlen);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("fill_rready", rready, 1'b1);
    chk("fill_ar_drop", arvalid, 1'b0);
    for (int b = 0; b < n; b++) begin
      seed++;
      exp_beats[b] = {32'hC0DE_0000 + 32'(seed), 32'(b),
                      64'h0123_4567_89AB_CDEF ^ 64'(seed * 977)};
      rvalid = 1'b1;
      rdata  = exp_beats[b];
      rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      rlast  = (b == n - 1);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    chk("req_valid", w_valid, 1'b1);
    chk("req_addr", w_addr, e_addr);
    chk("req_len", w_len, e_len);
    chk("req_not_empty", w_empty, 1'b0);
    for (int b = 0; b < n; b++) begin
      chk("payload", w_data, exp_beats[b]);
      w_rd = 1'b1;
      tick();
    end
    w_rd = 1'b0;
    chk("drained", w_empty, 1'b1);
    chk("valid_hold", w_valid, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("valid_drop", w_valid, 1'b0);
    if (last) begin
      chk("complete", complete, 1'b1);
      chk("busy_clr", busy, 1'b0);
      tick();
      chk("complete_pulse", complete, 1'b0);
    end else begin
      chk("no_complete", complete, 1'b0);
    end
  endtask

  initial begin
    #1;
    chk_reset_vals();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_reset_vals();

    // 256B MPS with a 4KB crossing after 128 bytes
    start_xfer(32'h1000_0F80, 32'h2000_0000, 32'h200, 3'b001);
    do_chunk(32'h2000_0000, 8'd7, 32'h1000_0F80, 10'd32, -1, 1'b0);
    do_chunk(32'h2000_0080, 8'd15, 32'h1000_1000, 10'd64, -1, 1'b0);
    do_chunk(32'h2000_0180, 8'd7, 32'h1000_1100, 10'd32, -1, 1'b1);
    chk("t1_error", error, 1'b0);

    // oversized MPS code clamps to 512B
    start_xfer(32'h0000_0000, 32'h3000_0000, 32'h400, 3'b101);
    do_chunk(32'h3000_0000, 8'd31, 32'h0000_0000, 10'd128, -1, 1'b0);
    do_chunk(32'h3000_0200, 8'd31, 32'h0000_0200, 10'd128, -1, 1'b1);

    // single 16-byte beat
    start_xfer(32'h4000_0000, 32'h5000_0000, 32'h10, 3'b001);
    do_chunk(32'h5000_0000, 8'd0, 32'h4000_0000, 10'd4, -1, 1'b1);

    // bad rresp on beat 3 of 4
    start_xfer(32'h4000_1000, 32'h5000_1000, 32'h40, 3'b000);
    do_chunk(32'h5000_1000, 8'd3, 32'h4000_1000, 10'd16, 2, 1'b1);
    chk("err_sticky", error, 1'b1);
    tick();
    chk("err_held", error, 1'b1);

    // zero length, with a second start held while busy
    start_xfer(32'h0, 32'h0, 32'h0, 3'b000);
    chk("zero_complete", complete, 1'b1);
    chk("zero_err_clr", error, 1'b0);
    x_len = 32'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_pulse_end", complete, 1'b0);
    chk("zero_busy_clr", busy, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("ignored_start_ar", arvalid, 1'b0);
    chk("ignored_start_busy", busy, 1'b0);

    // reset asserted mid-FILL
    start_xfer(32'h6000_0000, 32'h7000_0000, 32'h40, 3'b000);
    chk("t6_araddr", araddr, 32'h7000_0000);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1;
      rdata  = {4{32'hDEAD_0000 + 32'(b)}};
      tick();
    end
    rvalid = 1'b0;
    chk("t6_not_empty", w_empty, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    tick();
    rst = 1'b0;
    tick();
    chk_reset_vals();
    start_xfer(32'h8000_0FF0, 32'h9000_0000, 32'h10, 3'b001);
    do_chunk(32'h9000_0000, 8'd0, 32'h8000_0FF0, 10'd4, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
